// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - single-cycle ALU execute stage with registered results and branch target
//
// Purpose: decodes the ALU select from main-control aluop and the R-type funct
// field, computes the 32-bit ALU result and flags, and computes pc+4 and the
// branch target. All outputs are registered one cycle after an in_valid edge.
//
// Optional feature: define ALU_EXEC_OVF_EN to add the registered signed-overflow
// output ovf (add/sub only).
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset, clears every output
//   in_valid       in   capture enable for operands and control
//   aluop1, aluop0 in   ALU operation class from main control
//   funct[3:0]     in   R-type function field
//   a[31:0]        in   operand A
//   b[31:0]        in   operand B
//   pc[31:0]       in   current program counter
//   imm[31:0]      in   sign-extended byte branch offset
//   out_valid      out  registered in_valid
//   gout[2:0]      out  registered decoded ALU select
//   result[31:0]   out  registered ALU result
//   zero/neg/carry out  registered flags
//   pc_plus4       out  registered pc + 4
//   branch_target  out  registered pc + 4 + imm
//   ovf            out  registered signed overflow (ALU_EXEC_OVF_EN only)

module alu_exec_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        aluop1,
    input  logic        aluop0,
    input  logic [3:0]  funct,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    output logic        out_valid,
    output logic [2:0]  gout,
    output logic [31:0] result,
    output logic        zero,
    output logic        neg,
    output logic        carry,
    output logic [31:0] pc_plus4,
    output logic [31:0] branch_target
`ifdef ALU_EXEC_OVF_EN
    ,
    output logic        ovf
`endif
);

    localparam logic [2:0] G_AND = 3'b000;
    localparam logic [2:0] G_OR  = 3'b001;
    localparam logic [2:0] G_ADD = 3'b010;
    localparam logic [2:0] G_NOR = 3'b100;
    localparam logic [2:0] G_SUB = 3'b110;
    localparam logic [2:0] G_SLT = 3'b111;

    logic        out_valid_d, out_valid_q;
    logic [2:0]  gout_d, gout_q;
    logic [31:0] result_d, result_q;
    logic        zero_d, zero_q;
    logic        neg_d, neg_q;
    logic        carry_d, carry_q;
    logic [31:0] pc_plus4_d, pc_plus4_q;
    logic [31:0] branch_target_d, branch_target_q;
`ifdef ALU_EXEC_OVF_EN
    logic        ovf_d, ovf_q;
`endif

    logic [2:0]  sel;
    logic [32:0] sum33;
    logic [32:0] diff33;
    logic [31:0] alu_res;
    logic        alu_carry;
    logic [31:0] pc4;

    // Select decode; funct patterns are checked in priority order so that
    // e.g. 0111 resolves to sub before the or pattern is considered.
    always_comb begin
        sel = G_ADD;
        if (aluop0) begin
            sel = G_SUB;
        end else if (aluop1) begin
            if (funct == 4'b0000)            sel = G_ADD;
            else if (funct[3] && funct[1])   sel = G_SLT;
            else if (!funct[3] && funct[1])  sel = G_SUB;
            else if (funct[2] && funct[0])   sel = G_OR;
            else if (funct[2] && !funct[0])  sel = G_AND;
            else                             sel = G_ADD;
        end
    end

    // Subtraction as a + ~b + 1 so bit 32 is the no-borrow carry.
    assign sum33  = {1'b0, a} + {1'b0, b};
    assign diff33 = {1'b0, a} + {1'b0, ~b} + 33'd1;
    assign pc4    = pc + 32'd4;

    always_comb begin
        alu_res   = 32'd0;
        alu_carry = 1'b0;
        case (sel)
            G_AND: alu_res = a & b;
            G_OR:  alu_res = a | b;
            G_ADD: begin
                alu_res   = sum33[31:0];
                alu_carry = sum33[32];
            end
            G_SUB: begin
                alu_res   = diff33[31:0];
                alu_carry = diff33[32];
            end
            G_SLT: begin
                // True signed compare, immune to subtraction overflow.
                alu_res   = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                alu_carry = diff33[32];
            end
            G_NOR: alu_res = ~(a | b);
            default: begin
                alu_res   = 32'd0;
                alu_carry = 1'b0;
            end
        endcase
    end

    // Data/flag registers only load on a valid edge; out_valid tracks in_valid.
    always_comb begin
        out_valid_d     = in_valid;
        gout_d          = gout_q;
        result_d        = result_q;
        zero_d          = zero_q;
        neg_d           = neg_q;
        carry_d         = carry_q;
        pc_plus4_d      = pc_plus4_q;
        branch_target_d = branch_target_q;
`ifdef ALU_EXEC_OVF_EN
        ovf_d           = ovf_q;
`endif
        if (in_valid) begin
            gout_d          = sel;
            result_d        = alu_res;
            zero_d          = (alu_res == 32'd0);
            neg_d           = alu_res[31];
            carry_d         = alu_carry;
            pc_plus4_d      = pc4;
            branch_target_d = pc4 + imm;
`ifdef ALU_EXEC_OVF_EN
            case (sel)
                G_ADD:   ovf_d = (a[31] == b[31]) && (alu_res[31] != a[31]);
                G_SUB:   ovf_d = (a[31] != b[31]) && (alu_res[31] != a[31]);
                default: ovf_d = 1'b0;
            endcase
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q     <= 1'b0;
            gout_q          <= 3'b000;
            result_q        <= 32'd0;
            zero_q          <= 1'b0;
            neg_q           <= 1'b0;
            carry_q         <= 1'b0;
            pc_plus4_q      <= 32'd0;
            branch_target_q <= 32'd0;
`ifdef ALU_EXEC_OVF_EN
            ovf_q           <= 1'b0;
`endif
        end else begin
            out_valid_q     <= out_valid_d;
            gout_q          <= gout_d;
            result_q        <= result_d;
            zero_q          <= zero_d;
            neg_q           <= neg_d;
            carry_q         <= carry_d;
            pc_plus4_q      <= pc_plus4_d;
            branch_target_q <= branch_target_d;
`ifdef ALU_EXEC_OVF_EN
            ovf_q           <= ovf_d;
`endif
        end
    end

    assign out_valid     = out_valid_q;
    assign gout          = gout_q;
    assign result        = result_q;
    assign zero          = zero_q;
    assign neg           = neg_q;
    assign carry         = carry_q;
    assign pc_plus4      = pc_plus4_q;
    assign branch_target = branch_target_q;
`ifdef ALU_EXEC_OVF_EN
    assign ovf           = ovf_q;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard testbench for alu_exec_unit
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        aluop1, aluop0;
    logic [3:0]  funct;
    logic [31:0] a, b, pc, imm;
    logic        out_valid;
    logic [2:0]  gout;
    logic [31:0] result;
    logic        zero, neg, carry;
    logic [31:0] pc_plus4, branch_target;
`ifdef ALU_EXEC_OVF_EN
    logic        ovf;
`endif

    alu_exec_unit dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .aluop1(aluop1),
        .aluop0(aluop0),
        .funct(funct),
        .a(a),
        .b(b),
        .pc(pc),
        .imm(imm),
        .out_valid(out_valid),
        .gout(gout),
        .result(result),
        .zero(zero),
        .neg(neg),
        .carry(carry),
        .pc_plus4(pc_plus4),
        .branch_target(branch_target)
`ifdef ALU_EXEC_OVF_EN
        ,
        .ovf(ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  aluop;
        logic [3:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  gout;
        logic [31:0] result;
        logic        zero;
        logic        neg;
        logic        carry;
        logic        ovf;
        logic [31:0] pc4;
        logic [31:0] bt;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: pops one expected entry per valid output.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_out_valid: got 1 expected 0");
            end else begin
                vec_t e;
                e = exp_q.pop_front();
                chk("gout", {29'd0, gout}, {29'd0, e.gout});
                chk("result", result, e.result);
                chk("flags_zero_neg_carry", {29'd0, zero, neg, carry},
                    {29'd0, e.zero, e.neg, e.carry});
                chk("pc_plus4", pc_plus4, e.pc4);
                chk("branch_target", branch_target, e.bt);
`ifdef ALU_EXEC_OVF_EN
                chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
            end
        end
    end

    function automatic vec_t mk(input logic [1:0] op, input logic [3:0] f,
                                input logic [31:0] va, input logic [31:0] vb,
                                input logic [31:0] vpc, input logic [31:0] vimm,
                                input logic [2:0] g, input logic [31:0] r,
                                input logic z, input logic n, input logic c, input logic o,
                                input logic [31:0] p4, input logic [31:0] t);
        vec_t v;
        v.aluop = op; v.funct = f; v.a = va; v.b = vb; v.pc = vpc; v.imm = vimm;
        v.gout = g; v.result = r; v.zero = z; v.neg = n; v.carry = c; v.ovf = o;
        v.pc4 = p4; v.bt = t;
        return v;
    endfunction

    task automatic issue(input vec_t v);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        {aluop1, aluop0} = v.aluop;
        funct = v.funct; a = v.a; b = v.b; pc = v.pc; imm = v.imm;
        exp_q.push_back(v);
    endtask

    initial begin
        vec_t add_ovf;
        rst_n = 1'b0; in_valid = 1'b0; aluop1 = 1'b0; aluop0 = 1'b0;
        funct = 4'd0; a = 32'd0; b = 32'd0; pc = 32'd0; imm = 32'd0;

        //         op     funct    a             b             pc            imm           gout    result        z    n    c    o    pc4           bt
        vecs.push_back(mk(2'b10, 4'b0000, 32'd5,        32'd7,        32'h0000_0008, 32'hFFFF_FFF8, 3'b010, 32'd12,       1'b0,1'b0,1'b0,1'b0, 32'h0000_000C, 32'h0000_0004));
        vecs.push_back(mk(2'b01, 4'b0000, 32'h10,       32'h10,       32'hFFFF_FFFC, 32'd0,         3'b110, 32'd0,        1'b1,1'b0,1'b1,1'b0, 32'd0,         32'd0));
        vecs.push_back(mk(2'b10, 4'b1010, 32'h8000_0000,32'd1,        32'h100,       32'h10,        3'b111, 32'd1,        1'b0,1'b0,1'b1,1'b0, 32'h104,       32'h114));
        vecs.push_back(mk(2'b10, 4'b1010, 32'd1,        32'h8000_0000,32'd0,         32'd0,         3'b111, 32'd0,        1'b1,1'b0,1'b0,1'b0, 32'd4,         32'd4));
        vecs.push_back(mk(2'b10, 4'b0100, 32'hF0F0_00FF,32'h0FF0_0F0F,32'h20,        32'h20,        3'b000, 32'h00F0_000F,1'b0,1'b0,1'b0,1'b0, 32'h24,        32'h44));
        vecs.push_back(mk(2'b10, 4'b0101, 32'hF0F0_00FF,32'h0FF0_0F0F,32'h20,        32'h20,        3'b001, 32'hFFF0_0FFF,1'b0,1'b1,1'b0,1'b0, 32'h24,        32'h44));
        vecs.push_back(mk(2'b00, 4'b1111, 32'h7FFF_FFFF,32'd1,        32'h40,        32'd0,         3'b010, 32'h8000_0000,1'b0,1'b1,1'b0,1'b1, 32'h44,        32'h44));
        vecs.push_back(mk(2'b00, 4'b0000, 32'hFFFF_FFFF,32'd1,        32'h40,        32'd0,         3'b010, 32'd0,        1'b1,1'b0,1'b1,1'b0, 32'h44,        32'h44));
        vecs.push_back(mk(2'b11, 4'b0000, 32'd3,        32'd5,        32'h40,        32'd0,         3'b110, 32'hFFFF_FFFE,1'b0,1'b1,1'b0,1'b0, 32'h44,        32'h44));
        vecs.push_back(mk(2'b10, 4'b0010, 32'd10,       32'd3,        32'h40,        32'd0,         3'b110, 32'd7,        1'b0,1'b0,1'b1,1'b0, 32'h44,        32'h44));
        vecs.push_back(mk(2'b10, 4'b0111, 32'd4,        32'd4,        32'h40,        32'd0,         3'b110, 32'd0,        1'b1,1'b0,1'b1,1'b0, 32'h44,        32'h44));
        vecs.push_back(mk(2'b10, 4'b1000, 32'd2,        32'd3,        32'h40,        32'd0,         3'b010, 32'd5,        1'b0,1'b0,1'b0,1'b0, 32'h44,        32'h44));
        vecs.push_back(mk(2'b10, 4'b1101, 32'h0F,       32'hF0,       32'h40,        32'd0,         3'b001, 32'hFF,       1'b0,1'b0,1'b0,1'b0, 32'h44,        32'h44));
        vecs.push_back(mk(2'b10, 4'b1110, 32'hFFFF_FFFF,32'd0,        32'h40,        32'd0,         3'b111, 32'd1,        1'b0,1'b0,1'b1,1'b0, 32'h44,        32'h44));
        vecs.push_back(mk(2'b00, 4'b0000, 32'h8000_0000,32'h8000_0000,32'h40,        32'h8,         3'b010, 32'd0,        1'b1,1'b0,1'b1,1'b1, 32'h44,        32'h4C));
        add_ovf = vecs[6];

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {31'd0, |{out_valid, gout, result, zero, neg, carry, pc_plus4, branch_target}}, 32'd0);
        rst_n = 1'b1;

        // Back-to-back burst, one vector per cycle.
        foreach (vecs[i]) issue(vecs[i]);

        // Idle edge: out_valid drops, data holds.
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_hold_result", result, vecs[vecs.size()-1].result);
        chk("idle_hold_bt", branch_target, vecs[vecs.size()-1].bt);

        // Mid-stream reset: valid operation presented, reset asserted between edges.
        @(posedge clk);
        #1;
        in_valid = 1'b1; {aluop1, aluop0} = 2'b00; a = 32'd9; b = 32'd9; pc = 32'h80; imm = 32'd4;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {31'd0, |{out_valid, gout, result, zero, neg, carry, pc_plus4, branch_target}}, 32'd0);
`ifdef ALU_EXEC_OVF_EN
        chk("async_reset_ovf", {31'd0, ovf}, 32'd0);
`endif
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_discard", {31'd0, out_valid}, 32'd0);

        // First valid after release behaves normally.
        issue(add_ovf);
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        begin
            int budget;
            budget = 0;
            while (exp_q.size() != 0 && budget < 100) begin
                @(posedge clk);
                budget++;
            end
        end
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
